// File: rtl/monitor_overlay_ctrl.sv
// Front-panel halt/step controller for the 6502 monitor: debounces the panel buttons,
// raises NMI to stop the CPU, and overlays control RAM onto page $FF while halted.
module monitor_overlay_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [3:0]  NMI_LOW_CYCLES  = 4'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_cycle,
   input  logic [15:0] A,
   input  logic        write,
   input  logic        sync,
   input  logic        b_runhalt,
   input  logic        b_step,
   output logic        nmi_n,
   output logic        overlay,
   output logic        ctrl_cs,
   output logic [7:0]  status,
   output logic        halted,
   output logic [1:0]  fsm_state
);

   // Bus protocol: A, write and sync are only meaningful in a clk where cpu_cycle=1.
   // cpu_cycle is a one-clk strobe with no back-pressure; every state transition
   // driven by the CPU bus is qualified by it.

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_ARMED   = 2'd1,
      ST_OVERLAY = 2'd2,
      ST_RESUME  = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [1:0]  raw_btn;
   logic [1:0]  sync1;
   logic [1:0]  sync2;
   logic [1:0]  level;
   logic [1:0]  press;
   logic [15:0] db_cnt [2];

   logic        run_mode;
   logic        step_pending;
   logic        nmi_active;
   logic [3:0]  nmi_cnt;

   logic        rh_press;
   logic        st_press;
   logic        page_ff;
   logic        vec_fetch;
   logic        resume_wr;
   logic        resume_exit;
   logic        arm_entry;

   assign raw_btn  = {b_step, b_runhalt};
   assign rh_press = press[0];
   assign st_press = press[1];

   // Two-stage synchronizer per button ahead of the debounce counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= raw_btn;
         sync2 <= sync1;
      end
   end

   // Level flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it;
   // a flip to 1 emits a one-clk press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level  <= 2'b00;
         press  <= 2'b00;
         db_cnt <= '{16'd0, 16'd0};
      end else begin
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= 16'd0;
            end else if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
               level[i]  <= sync2[i];
               press[i]  <= sync2[i];
               db_cnt[i] <= 16'd0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign page_ff     = (A[15:8] == 8'hFF);
   assign vec_fetch   = cpu_cycle && !write && (A == 16'hFFFA);
   assign resume_wr   = cpu_cycle && write && (A == 16'hFFF9);
   assign resume_exit = (state == ST_RESUME) && cpu_cycle && sync && !page_ff;
   assign arm_entry   = (next_state == ST_ARMED) && (state != ST_ARMED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_mode <= 1'b1;
      end else if (rh_press) begin
         run_mode <= !run_mode;
      end
   end

   // Leaving the monitor consumes the pending step request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_pending <= 1'b0;
      end else if (resume_exit) begin
         step_pending <= 1'b0;
      end else if (st_press && !run_mode) begin
         step_pending <= 1'b1;
      end
   end

   // One NMI pulse per entry to ARMED, lasting NMI_LOW_CYCLES bus strobes even if
   // the CPU has already moved the FSM on to OVERLAY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_active <= 1'b0;
         nmi_cnt    <= 4'd0;
      end else if (arm_entry) begin
         nmi_active <= 1'b1;
         nmi_cnt    <= 4'd0;
      end else if (nmi_active && cpu_cycle) begin
         if (nmi_cnt == NMI_LOW_CYCLES - 4'd1) begin
            nmi_active <= 1'b0;
         end
         nmi_cnt <= nmi_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_NORMAL;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_NORMAL: begin
            if (!run_mode || rh_press) begin
               next_state = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (vec_fetch) begin
               next_state = ST_OVERLAY;
            end
         end
         ST_OVERLAY: begin
            if (resume_wr) begin
               next_state = ST_RESUME;
            end
         end
         ST_RESUME: begin
            if (resume_exit) begin
               next_state = run_mode ? ST_NORMAL : ST_ARMED;
            end
         end
         default: next_state = ST_NORMAL;
      endcase
   end

   // The NMI vector low byte itself must come from control RAM, so ARMED overlays
   // the $FFFA read combinationally before the FSM has moved.
   always_comb begin
      overlay = 1'b0;
      halted  = 1'b0;
      case (state)
         ST_ARMED:   overlay = (A == 16'hFFFA) && !write;
         ST_OVERLAY: begin
            overlay = page_ff;
            halted  = 1'b1;
         end
         ST_RESUME:  overlay = page_ff;
         default:    overlay = 1'b0;
      endcase
   end

   assign ctrl_cs   = overlay && cpu_cycle;
   assign nmi_n     = !nmi_active;
   assign status    = {6'b000000, run_mode, step_pending};
   assign fsm_state = state;

endmodule

// File: tb/tb_monitor_overlay_ctrl.sv
// Randomized self-checking bench for monitor_overlay_ctrl against a transaction-level
// model of the halt/step/resume protocol.
module tb_monitor_overlay_ctrl;

   localparam int DB      = 8;
   localparam int NMI_LOW = 4;

   localparam logic [1:0] P_NORMAL  = 2'd0;
   localparam logic [1:0] P_ARMED   = 2'd1;
   localparam logic [1:0] P_OVERLAY = 2'd2;
   localparam logic [1:0] P_RESUME  = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_cycle;
   logic [15:0] a;
   logic        write;
   logic        sync;
   logic        b_runhalt;
   logic        b_step;
   logic        nmi_n;
   logic        overlay;
   logic        ctrl_cs;
   logic [7:0]  status;
   logic        halted;
   logic [1:0]  fsm_state;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          low_strobes = 0;
   int          falls = 0;
   logic        prev_nmi = 1'b1;

   int          exp_falls;
   logic        exp_run;
   logic        exp_step;
   logic [1:0]  phase;

   monitor_overlay_ctrl #(
      .DEBOUNCE_CYCLES(16'(DB)),
      .NMI_LOW_CYCLES (4'd4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_cycle (cpu_cycle),
      .A         (a),
      .write     (write),
      .sync      (sync),
      .b_runhalt (b_runhalt),
      .b_step    (b_step),
      .nmi_n     (nmi_n),
      .overlay   (overlay),
      .ctrl_cs   (ctrl_cs),
      .status    (status),
      .halted    (halted),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // NMI observer: cumulative falling edges and bus strobes seen while NMI is low.
   always @(negedge clk) begin
      if (cpu_cycle && !nmi_n) low_strobes++;
      if (prev_nmi && !nmi_n) falls++;
      prev_nmi = nmi_n;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] exp_status();
      return {6'b000000, exp_run, exp_step};
   endfunction

   task automatic check_model(input string tag);
      check({tag, "_state"},  16'(fsm_state), 16'(phase));
      check({tag, "_halted"}, 16'(halted),    16'(phase == P_OVERLAY));
      check({tag, "_status"}, 16'(status),    16'(exp_status()));
   endtask

   // One CPU bus cycle; the model applies the protocol rules after the strobe.
   task automatic bus(input logic [15:0] addr, input logic wr, input logic sy);
      logic exp_ov;
      exp_ov = ((phase == P_ARMED) && (addr == 16'hFFFA) && !wr) ||
               (((phase == P_OVERLAY) || (phase == P_RESUME)) && (addr[15:8] == 8'hFF));
      @(posedge clk); #1;
      a = addr; write = wr; sync = sy; cpu_cycle = 1'b1;
      @(negedge clk);
      check("overlay", 16'(overlay), 16'(exp_ov));
      check("ctrl_cs", 16'(ctrl_cs), 16'(exp_ov));
      if (!wr && (addr == 16'hFFF8) && exp_ov)
         check("status_read", 16'(status), 16'(exp_status()));
      @(posedge clk); #1;
      cpu_cycle = 1'b0; write = 1'b0; sync = 1'b0;
      if ((phase == P_ARMED) && (addr == 16'hFFFA) && !wr) begin
         phase = P_OVERLAY;
      end else if ((phase == P_OVERLAY) && wr && (addr == 16'hFFF9)) begin
         phase = P_RESUME;
      end else if ((phase == P_RESUME) && sy && (addr[15:8] != 8'hFF)) begin
         exp_step = 1'b0;
         if (exp_run) phase = P_NORMAL;
         else begin
            phase = P_ARMED;
            exp_falls++;
         end
      end
      check_model("bus");
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   // Long press and release: both edges held well beyond the debounce window.
   task automatic press(input int which);
      @(posedge clk); #1;
      if (which == 0) b_runhalt = 1'b1;
      else            b_step    = 1'b1;
      repeat (DB + 4) @(posedge clk);
      #1;
      b_runhalt = 1'b0; b_step = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1;
      if (which == 0) begin
         exp_run = !exp_run;
         if ((phase == P_NORMAL) && !exp_run) begin
            phase = P_ARMED;
            exp_falls++;
         end
      end else if (!exp_run) begin
         exp_step = 1'b1;
      end
      check_model(which == 0 ? "press_rh" : "press_step");
   endtask

   // Pulse shorter than the debounce window: must leave everything untouched.
   task automatic glitch(input int which, input int len);
      @(posedge clk); #1;
      if (which == 0) b_runhalt = 1'b1;
      else            b_step    = 1'b1;
      repeat (len) @(posedge clk);
      #1;
      b_runhalt = 1'b0; b_step = 1'b0;
      repeat (DB + 4) @(posedge clk);
      #1;
      check_model("glitch");
   endtask

   initial begin
      int          low0;
      int          f0;
      logic [15:0] addr;
      logic        wr;

      rst_n = 1'b0; cpu_cycle = 1'b0; write = 1'b0; sync = 1'b0; a = 16'h0000;
      b_runhalt = 1'b0; b_step = 1'b0;
      exp_run = 1'b1; exp_step = 1'b0; phase = P_NORMAL; exp_falls = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_nmi_n",   16'(nmi_n),   16'd1);
      check("rst_overlay", 16'(overlay), 16'd0);
      check("rst_ctrl_cs", 16'(ctrl_cs), 16'd0);
      check("rst_status",  16'(status),  16'h0002);
      check("rst_halted",  16'(halted),  16'd0);
      check("rst_state",   16'(fsm_state), 16'(P_NORMAL));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Idle running: nothing may ever be overlaid, including $FFFA.
      for (int i = 0; i < 1000; i++) begin
         bus(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("idle_nmi_n", 16'(nmi_n), 16'd1);
      end
      bus(16'hFFFA, 1'b0, 1'b0);

      glitch(0, 5);
      glitch(0, $urandom_range(1, DB - 3));
      glitch(1, $urandom_range(1, DB - 3));
      press(1);
      check("run_nmi_falls", 16'(falls), 16'(exp_falls));

      for (int s = 0; s < 6; s++) begin
         if (phase == P_NORMAL) press(0);
         if ($urandom_range(0, 3) == 0) press(0);

         low0 = low_strobes;
         for (int k = 0; k < 6; k++)
            bus(16'($urandom_range(0, 16'hFEFF)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("nmi_low_strobes", 16'(low_strobes - low0), 16'(NMI_LOW));
         check("nmi_falls",       16'(falls), 16'(exp_falls));
         check("nmi_released",    16'(nmi_n), 16'd1);

         bus(16'hFFFA, 1'b0, 1'b1);
         bus(16'hFFFB, 1'b0, 1'b0);
         bus(16'h1234, 1'b0, 1'b0);
         for (int k = 0; k < 4; k++) begin
            addr = 16'($urandom_range(0, 65535));
            wr   = 1'($urandom_range(0, 1));
            if (wr && (addr == 16'hFFF9)) addr = 16'hFFF8;
            bus(addr, wr, 1'b0);
         end
         if ($urandom_range(0, 1) == 1) press(1);
         if ($urandom_range(0, 2) == 0) press(0);
         bus(16'hFFF8, 1'b0, 1'b0);
         bus(16'hFFF9, 1'b1, 1'b0);
         bus(16'hFF10, 1'b0, 1'b1);
         bus(16'h0400, 1'b0, 1'b0);
         bus(16'($urandom_range(0, 16'hFEFF)), 1'b0, 1'b1);

         if (phase == P_NORMAL) begin
            f0 = falls;
            for (int k = 0; k < 4; k++) bus(16'($urandom_range(0, 16'hFEFF)), 1'b0, 1'b1);
            check("nmi_quiet_falls", 16'(falls - f0), 16'd0);
            check("nmi_quiet_level", 16'(nmi_n), 16'd1);
         end
      end

      // Asynchronous reset while halted with NMI still asserted.
      if (phase == P_NORMAL) press(0);
      bus(16'hFFFA, 1'b0, 1'b1);
      check("pre_rst_nmi_n",  16'(nmi_n),  16'd0);
      check("pre_rst_halted", 16'(halted), 16'd1);
      @(posedge clk);
      a = 16'hFFF8;
      #3 rst_n = 1'b0;
      #1;
      check("arst_nmi_n",   16'(nmi_n),   16'd1);
      check("arst_overlay", 16'(overlay), 16'd0);
      check("arst_halted",  16'(halted),  16'd0);
      check("arst_status",  16'(status),  16'h0002);
      check("arst_state",   16'(fsm_state), 16'(P_NORMAL));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_run = 1'b1; exp_step = 1'b0; phase = P_NORMAL;
      @(posedge clk); #1;
      check_model("post_rst");
      check("post_rst_nmi_n", 16'(nmi_n), 16'd1);
      for (int k = 0; k < 4; k++) bus(16'($urandom_range(16'hFF00, 16'hFFFF)), 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
